requant_param_streamer: RTL and testbench

REQUANT_PARAM_STREAMER -- requirements
Module: requant_param_streamer

---
 rtl/requant_pkg.sv | 22 ++
 rtl/requant_param_streamer_if.sv | 58 +++++
 rtl/rps_stream_ctr.sv | 65 ++++++
 rtl/requant_param_streamer.sv | 146 ++++++++++++++
 tb/tb_requant_param_streamer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/requant_pkg.sv
// requant_pkg
//   Shared definitions for the requantisation datapath.
//   - D_W / D_W_ACC : default exponent width and bias/multiplier width
//   - requant_param_t : one per-channel parameter word {bias, m, e}, MSB first
//   - rps_state_t : control states of the parameter streamer
package requant_pkg;

    localparam int D_W     = 8;
    localparam int D_W_ACC = 32;

    typedef struct packed {
        logic [D_W_ACC-1:0] bias;
        logic [D_W_ACC-1:0] m;
        logic [D_W-1:0]     e;
    } requant_param_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rps_state_t;

endpackage

// File: rtl/requant_param_streamer_if.sv
// requant_param_streamer_if
//   Bundles the table-load stream and the three parameter output streams.
//   - ld_*  : load stream, word = {bias, m, e}
//   - b_*   : bias stream      (D_W_ACC wide)
//   - m_*   : multiplier stream (D_W_ACC wide)
//   - e_*   : exponent stream   (D_W wide)
//   modport master : the streamer (sinks ld_*, sources b_/m_/e_*)
//   modport slave  : the environment on the other side
interface requant_param_streamer_if
    import requant_pkg::*;
#(
    parameter int D_W     = requant_pkg::D_W,
    parameter int D_W_ACC = requant_pkg::D_W_ACC
);

    logic [2*D_W_ACC+D_W-1:0] ld_tdata;
    logic                     ld_tvalid;
    logic                     ld_tready;
    logic                     ld_tlast;

    logic [D_W_ACC-1:0] b_tdata;
    logic               b_tvalid;
    logic               b_tready;
    logic               b_tlast;

    logic [D_W_ACC-1:0] m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tlast;

    logic [D_W-1:0] e_tdata;
    logic           e_tvalid;
    logic           e_tready;
    logic           e_tlast;

    modport master (
        input  ld_tdata, ld_tvalid, ld_tlast,
        output ld_tready,
        output b_tdata, b_tvalid, b_tlast,
        input  b_tready,
        output m_tdata, m_tvalid, m_tlast,
        input  m_tready,
        output e_tdata, e_tvalid, e_tlast,
        input  e_tready
    );

    modport slave (
        output ld_tdata, ld_tvalid, ld_tlast,
        input  ld_tready,
        input  b_tdata, b_tvalid, b_tlast,
        output b_tready,
        input  m_tdata, m_tvalid, m_tlast,
        output m_tready,
        input  e_tdata, e_tvalid, e_tlast,
        output e_tready
    );

endinterface

// File: rtl/rps_stream_ctr.sv
// rps_stream_ctr
//   Per-stream sequencer: walks channel 0..ch_last for rows 0..row_last,
//   advancing only on its own valid/ready handshake.
//   Ports:
//   - clk, rst      : clock, synchronous active-high reset
//   - start         : accepted tile start (restarts at channel 0, row 0)
//   - ch_last       : index of the last channel in a row
//   - row_last      : index of the last row in the tile
//   - tready        : downstream ready
//   - tvalid, tlast : stream valid and end-of-row marker
//   - idx           : table index currently presented
//   - done          : set after the final beat, cleared by the next start
module rps_stream_ctr
    import requant_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] ch_last,
    input  logic [15:0]      row_last,
    input  logic             tready,
    output logic             tvalid,
    output logic             tlast,
    output logic [IDX_W-1:0] idx,
    output logic             done
);

    logic [IDX_W-1:0] ch;
    logic [15:0]      row;
    logic             valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ch    <= '0;
            row   <= '0;
            valid <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            ch    <= '0;
            row   <= '0;
            valid <= 1'b1;
            done  <= 1'b0;
        end else if (valid && tready) begin
            if (ch == ch_last) begin
                ch <= '0;
                // Final beat of the tile: stop presenting data
                if (row == row_last) begin
                    valid <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    row <= row + 16'd1;
                end
            end else begin
                ch <= ch + IDX_W'(1);
            end
        end
    end

    assign tvalid = valid;
    assign tlast  = valid && (ch == ch_last);
    assign idx    = ch;

endmodule

// File: rtl/requant_param_streamer.sv
// requant_param_streamer
//   Holds a per-channel requantisation parameter table and replays it as
//   three independently flow-controlled streams (bias, m, e) over a tile of
//   cfg_num_rows rows of cfg_num_ch channels.
//   Ports:
//   - clk, rst     : clock, synchronous active-high reset (table is kept)
//   - cfg_num_ch   : channels per row, sampled on an accepted start
//   - cfg_num_rows : rows per tile, sampled on an accepted start
//   - start        : tile start pulse
//   - busy         : high while streaming
//   - err          : one-cycle pulse on bad start config or load overflow
//   - bus          : load stream and the three output streams
module requant_param_streamer
    import requant_pkg::*;
#(
    parameter int D_W     = requant_pkg::D_W,
    parameter int D_W_ACC = requant_pkg::D_W_ACC,
    parameter int N_CH    = 64,
    localparam int CH_W   = $clog2(N_CH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_W-1:0]   cfg_num_ch,
    input  logic [15:0]       cfg_num_rows,
    input  logic              start,
    output logic              busy,
    output logic              err,
    requant_param_streamer_if.master bus
);

    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WORD_W = 2 * D_W_ACC + D_W;

    rps_state_t state;
    rps_state_t state_next;

    logic [WORD_W-1:0] tbl [N_CH];
    logic [CH_W-1:0]   ld_ptr;
    logic              ld_ovf;
    logic [IDX_W-1:0]  ch_last_q;
    logic [15:0]       row_last_q;

    logic             ld_fire;
    logic             ld_room;
    logic             cfg_ok;
    logic             start_ok;
    logic             start_bad;
    logic             all_done;
    logic [IDX_W-1:0] b_idx, m_idx, e_idx;
    logic             b_done, m_done, e_done;

    assign bus.ld_tready = (state == IDLE);
    assign busy          = (state == STREAM);

    assign ld_fire   = bus.ld_tvalid && (state == IDLE);
    assign ld_room   = ld_ptr < CH_W'(N_CH);
    assign cfg_ok    = (cfg_num_ch != '0) && (cfg_num_ch <= CH_W'(N_CH))
                       && (cfg_num_rows != '0);
    assign start_ok  = start && (state == IDLE) && cfg_ok;
    assign start_bad = start && (state == IDLE) && !cfg_ok;
    assign all_done  = b_done && m_done && e_done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = STREAM;
            STREAM:  if (all_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Table storage has no reset so its contents survive rst. A load beat
    // in the same cycle as a start lands before the first streamed read.
    always_ff @(posedge clk) begin
        if (ld_fire && ld_room) begin
            tbl[ld_ptr[IDX_W-1:0]] <= bus.ld_tdata;
        end
    end

    // Load pointer, overflow latch, error pulse and sampled tile geometry.
    // ld_ovf limits the overflow error to one pulse until the load ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_ptr     <= '0;
            ld_ovf     <= 1'b0;
            err        <= 1'b0;
            ch_last_q  <= '0;
            row_last_q <= '0;
        end else begin
            err <= start_bad || (ld_fire && !ld_room && !ld_ovf);
            if (ld_fire) begin
                if (bus.ld_tlast) begin
                    ld_ptr <= '0;
                    ld_ovf <= 1'b0;
                end else if (ld_room) begin
                    ld_ptr <= ld_ptr + CH_W'(1);
                end else begin
                    ld_ovf <= 1'b1;
                end
            end
            if (start_ok) begin
                ch_last_q  <= IDX_W'(cfg_num_ch - CH_W'(1));
                row_last_q <= cfg_num_rows - 16'd1;
            end
        end
    end

    rps_stream_ctr #(.IDX_W(IDX_W)) u_b_ctr (
        .clk(clk), .rst(rst), .start(start_ok),
        .ch_last(ch_last_q), .row_last(row_last_q),
        .tready(bus.b_tready), .tvalid(bus.b_tvalid), .tlast(bus.b_tlast),
        .idx(b_idx), .done(b_done)
    );

    rps_stream_ctr #(.IDX_W(IDX_W)) u_m_ctr (
        .clk(clk), .rst(rst), .start(start_ok),
        .ch_last(ch_last_q), .row_last(row_last_q),
        .tready(bus.m_tready), .tvalid(bus.m_tvalid), .tlast(bus.m_tlast),
        .idx(m_idx), .done(m_done)
    );

    rps_stream_ctr #(.IDX_W(IDX_W)) u_e_ctr (
        .clk(clk), .rst(rst), .start(start_ok),
        .ch_last(ch_last_q), .row_last(row_last_q),
        .tready(bus.e_tready), .tvalid(bus.e_tvalid), .tlast(bus.e_tlast),
        .idx(e_idx), .done(e_done)
    );

    // Each stream reads the table at its own index; data is stable during
    // a stall because the index only moves on handshake and the table is
    // only written in IDLE.
    assign bus.b_tdata = tbl[b_idx][WORD_W-1 -: D_W_ACC];
    assign bus.m_tdata = tbl[m_idx][D_W_ACC+D_W-1 -: D_W_ACC];
    assign bus.e_tdata = tbl[e_idx][D_W-1:0];

endmodule

// File: tb/tb_requant_param_streamer.sv
// tb_requant_param_streamer
//   Scoreboard bench: a model table tracks loads; each accepted start pushes
//   the expected {tlast, data} beats per stream, which are popped and
//   compared as the DUT hands them off.
module tb_requant_param_streamer;
    import requant_pkg::*;

    localparam int N_CH   = 64;
    localparam int CH_W   = $clog2(N_CH + 1);
    localparam int WORD_W = 2 * D_W_ACC + D_W;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH_W-1:0] cfg_num_ch;
    logic [15:0]     cfg_num_rows;
    logic            start;
    logic            busy;
    logic            err;

    requant_param_streamer_if #(.D_W(D_W), .D_W_ACC(D_W_ACC)) bus ();

    requant_param_streamer #(.D_W(D_W), .D_W_ACC(D_W_ACC), .N_CH(N_CH)) dut (
        .clk(clk),
        .rst(rst),
        .cfg_num_ch(cfg_num_ch),
        .cfg_num_rows(cfg_num_rows),
        .start(start),
        .busy(busy),
        .err(err),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic [WORD_W-1:0] model_tbl [N_CH];
    int                model_ptr = 0;
    bit                model_ovf = 1'b0;
    int                err_seen  = 0;
    int                err_exp   = 0;

    logic [D_W_ACC:0] b_q [$];
    logic [D_W_ACC:0] m_q [$];
    logic [D_W:0]     e_q [$];

    int m_stall = 0;
    bit mon_en  = 1'b1;
    int cyc     = 0;
    int b_fin   = 0;
    int m_fin   = 0;
    int e_fin   = 0;
    int b_beats = 0;

    task automatic checkOutput(input string tag, input logic [79:0] got,
                               input logic [79:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mkWord(input int bias, input int m, input int e);
        requant_param_t p;
        p.bias = D_W_ACC'(bias);
        p.m    = D_W_ACC'(m);
        p.e    = D_W'(e);
        return p;
    endfunction

    function automatic void modelLoad(input logic [WORD_W-1:0] word, input bit last);
        if (model_ptr < N_CH) begin
            model_tbl[model_ptr] = word;
            model_ptr++;
        end else if (!model_ovf) begin
            model_ovf = 1'b1;
            err_exp++;
        end
        if (last) begin
            model_ptr = 0;
            model_ovf = 1'b0;
        end
    endfunction

    function automatic bit allEmpty();
        return (b_q.size() == 0) && (m_q.size() == 0) && (e_q.size() == 0);
    endfunction

    // Compare any beat that will hand off at the coming edge; while stalled
    // the presented beat must already equal the head of the queue.
    task automatic observeStreams();
        logic [D_W_ACC:0] xb;
        logic [D_W:0]     xe;
        if (bus.b_tvalid === 1'b1) begin
            if (b_q.size() == 0) checkOutput("b_extra_beat", 1, 0);
            else if (bus.b_tready) begin
                xb = b_q.pop_front();
                checkOutput("b_beat", {bus.b_tlast, bus.b_tdata}, xb);
                b_beats++;
                if (b_q.size() == 0) b_fin = cyc;
            end else checkOutput("b_hold", {bus.b_tlast, bus.b_tdata}, b_q[0]);
        end
        if (bus.m_tvalid === 1'b1) begin
            if (m_q.size() == 0) checkOutput("m_extra_beat", 1, 0);
            else if (bus.m_tready) begin
                xb = m_q.pop_front();
                checkOutput("m_beat", {bus.m_tlast, bus.m_tdata}, xb);
                if (m_q.size() == 0) m_fin = cyc;
            end else checkOutput("m_hold", {bus.m_tlast, bus.m_tdata}, m_q[0]);
        end
        if (bus.e_tvalid === 1'b1) begin
            if (e_q.size() == 0) checkOutput("e_extra_beat", 1, 0);
            else if (bus.e_tready) begin
                xe = e_q.pop_front();
                checkOutput("e_beat", {bus.e_tlast, bus.e_tdata}, xe);
                if (e_q.size() == 0) e_fin = cyc;
            end else checkOutput("e_hold", {bus.e_tlast, bus.e_tdata}, e_q[0]);
        end
    endtask

    // One clock: inputs set by the caller apply to the coming edge;
    // outputs are sampled at the following falling edge.
    task automatic tick();
        bus.b_tready = 1'b1;
        bus.e_tready = 1'b1;
        bus.m_tready = (m_stall == 0);
        if (mon_en) observeStreams();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (m_stall > 0) m_stall--;
        if (err === 1'b1) err_seen++;
    endtask

    task automatic applyStimulus(input logic [WORD_W-1:0] word, input bit last);
        int n;
        n = 0;
        while (bus.ld_tready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) checkOutput("ld_ready_timeout", 0, 1);
        bus.ld_tdata  = word;
        bus.ld_tvalid = 1'b1;
        bus.ld_tlast  = last;
        modelLoad(word, last);
        tick();
        bus.ld_tvalid = 1'b0;
        bus.ld_tlast  = 1'b0;
    endtask

    task automatic startTile(input int num_ch, input int rows);
        bit ok;
        logic [WORD_W-1:0] w;
        ok = (num_ch >= 1) && (num_ch <= N_CH) && (rows >= 1);
        cfg_num_ch   = CH_W'(num_ch);
        cfg_num_rows = 16'(rows);
        if (ok) begin
            for (int r = 0; r < rows; r++) begin
                for (int c = 0; c < num_ch; c++) begin
                    w = model_tbl[c];
                    b_q.push_back({c == num_ch - 1, w[WORD_W-1 -: D_W_ACC]});
                    m_q.push_back({c == num_ch - 1, w[D_W_ACC+D_W-1 -: D_W_ACC]});
                    e_q.push_back({c == num_ch - 1, w[D_W-1:0]});
                end
            end
        end else begin
            err_exp++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        if (ok) begin
            checkOutput("start_valids", {bus.b_tvalid, bus.m_tvalid, bus.e_tvalid}, 3'b111);
            checkOutput("start_busy", busy, 1);
        end else begin
            checkOutput("bad_start_valids", {bus.b_tvalid, bus.m_tvalid, bus.e_tvalid}, 3'b000);
            checkOutput("bad_start_busy", busy, 0);
        end
    endtask

    task automatic runToIdle(input string tag);
        int n;
        int lag;
        n   = 0;
        lag = -1;
        while (n < 300 && !(allEmpty() && busy === 1'b0)) begin
            tick();
            n++;
            if (allEmpty()) lag++;
        end
        checkOutput({tag, "_timeout"}, n < 300, 1);
        checkOutput({tag, "_idle_lag"}, 80'(lag), 80'(1));
        checkOutput({tag, "_end_valids"}, {bus.b_tvalid, bus.m_tvalid, bus.e_tvalid}, 3'b000);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int b0;
        rst           = 1'b1;
        start         = 1'b0;
        cfg_num_ch    = '0;
        cfg_num_rows  = '0;
        bus.ld_tdata  = '0;
        bus.ld_tvalid = 1'b0;
        bus.ld_tlast  = 1'b0;
        bus.b_tready  = 1'b1;
        bus.m_tready  = 1'b1;
        bus.e_tready  = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_valids", {bus.b_tvalid, bus.m_tvalid, bus.e_tvalid}, 3'b000);
        checkOutput("reset_ld_ready", bus.ld_tready, 1);

        // Basic 4-channel, 2-row tile with free-running ready
        for (int i = 0; i < 4; i++) applyStimulus(mkWord(10 * i, i + 1, i), i == 3);
        startTile(4, 2);
        runToIdle("tile4x2");

        // Same tile with the m stream stalled for five cycles
        startTile(4, 2);
        m_stall = 5;
        runToIdle("tile_mstall");
        checkOutput("m_after_b", m_fin > b_fin, 1);
        checkOutput("m_after_e", m_fin > e_fin, 1);

        // Rejected starts: zero channels, zero rows, too many channels
        startTile(0, 1);
        startTile(4, 0);
        startTile(N_CH + 1, 1);
        tick();
        checkOutput("bad_start_err_count", err_seen, err_exp);

        // Overflow: 66 beats without tlast, then a closing tlast beat
        for (int i = 0; i < 66; i++) applyStimulus(mkWord(100 + i, 3 * i + 1, i % 17), 1'b0);
        applyStimulus(mkWord(999, 999, 99), 1'b1);
        tick();
        checkOutput("ovf_err_count", err_seen, err_exp);
        startTile(N_CH, 1);
        runToIdle("tile_full");

        // Load beat coinciding with start lands in channel 0
        bus.ld_tdata  = mkWord(7, 5, 3);
        bus.ld_tvalid = 1'b1;
        bus.ld_tlast  = 1'b1;
        modelLoad(mkWord(7, 5, 3), 1'b1);
        startTile(4, 1);
        bus.ld_tvalid = 1'b0;
        bus.ld_tlast  = 1'b0;
        checkOutput("first_b_is_7", bus.b_tdata, 7);
        runToIdle("tile_ldstart");

        // Reset after three beats of a 16-beat tile, then replay
        startTile(8, 2);
        b0 = b_beats;
        n  = 0;
        while (b_beats < b0 + 3 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("pre_rst_timeout", n < 50, 1);
        rst    = 1'b1;
        mon_en = 1'b0;
        tick();
        rst    = 1'b0;
        checkOutput("rst_valids", {bus.b_tvalid, bus.m_tvalid, bus.e_tvalid}, 3'b000);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_lasts", {bus.b_tlast, bus.m_tlast, bus.e_tlast}, 3'b000);
        b_q.delete();
        m_q.delete();
        e_q.delete();
        mon_en = 1'b1;
        startTile(8, 2);
        checkOutput("replay_b0", bus.b_tdata, 7);
        runToIdle("tile_replay");

        tick();
        checkOutput("final_err_count", err_seen, err_exp);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
